// File: rtl/ifetch_prefetch.sv
// Instruction-fetch prefetcher: sequential imem requests, DEPTH-entry buffer, redirect flush.
// Optional IFETCH_BYPASS_EN forwards an ack straight to the core when the buffer is empty.
`timescale 1ns/1ps

package ifetch_prefetch_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;
endpackage

module ifetch_prefetch
  import ifetch_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ins_valid,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  input  logic        ins_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   target_pc;
  fetch_entry_t  mem [DEPTH];
  fetch_entry_t  head;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  logic          fifo_empty;
  logic          ack_ok;
  logic          bypass_take;
  logic          pop;
  logic          push;
  logic          has_space;

  // Handshake decode, occupancy look-ahead and head presentation
  always_comb begin
    target_pc  = redirect_pc & ~32'h0000_0003;
    head       = mem[rptr];
    fifo_empty = (count == '0);
    ack_ok     = (state == REQ) && imem_ack && !redirect;
`ifdef IFETCH_BYPASS_EN
    bypass_take = ack_ok && fifo_empty && ins_ready;
`else
    bypass_take = 1'b0;
`endif
    pop       = !fifo_empty && ins_ready && !redirect;
    push      = ack_ok && !bypass_take;
    count_nx  = count + CW'(push) - CW'(pop);
    has_space = (count_nx < CW'(DEPTH));
    ins_valid = !fifo_empty;
    ins       = '0;
    ins_pc    = '0;
    if (!fifo_empty) begin
      ins    = head.word;
      ins_pc = head.pc;
    end
`ifdef IFETCH_BYPASS_EN
    else if (ack_ok) begin
      ins_valid = 1'b1;
      ins       = imem_rdata;
      ins_pc    = fetch_pc;
    end
`endif
  end

  // Fetch FSM; one request outstanding at most, redirect takes priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= target_pc;
          end else if (has_space) begin
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
            state     <= REQ;
          end
        end
        REQ: begin
          if (redirect) begin
            fetch_pc <= target_pc;
            if (imem_ack) begin
              imem_req <= 1'b0;
              state    <= IDLE;
            end else begin
              state <= DROP;
            end
          end else if (imem_ack) begin
            fetch_pc <= fetch_pc + 32'd4;
            if (has_space) begin
              imem_addr <= fetch_pc + 32'd4;
            end else begin
              imem_req <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        DROP: begin
          if (redirect) fetch_pc <= target_pc;
          // An ack here ends the stale request even if a new redirect arrives with it
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Buffer pointers and occupancy; redirect empties the buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (redirect) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      count <= count_nx;
    end
  end

  // Entry storage needs no reset; empty entries are masked on the output
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{pc: fetch_pc, word: imem_rdata};
  end

endmodule
